// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the slice-serial adder sequencer.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  // Bits needed to count n slice steps; never less than one.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_add_slice.sv
// Combinational SLICE-bit adder, time-shared across all slice steps.
module add_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder that walks one shared slice adder LSB-first, carry registered between steps.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = idx_width(NSLICE);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_width_check
      $error("adder_seq_ctrl: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic [IW-1:0]     idx_reg;
  logic              carry_reg;
  logic              cout_reg;
  logic [SLICE-1:0]  slice_a, slice_b, slice_sum;
  logic              slice_cout;
  logic              last_step;

  assign slice_a   = a_reg[idx_reg*SLICE +: SLICE];
  assign slice_b   = b_reg[idx_reg*SLICE +: SLICE];
  assign last_step = (idx_reg == IW'(NSLICE - 1));

  add_slice #(.SLICE(SLICE)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          carry_reg <= slice_cout;
          idx_reg   <= idx_reg + IW'(1);
          if (last_step) cout_reg <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  // Each result slice owns its register and only loads on its own step.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_res
      logic [SLICE-1:0] part_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          part_reg <= '0;
        end else if (state_reg == RUN && idx_reg == IW'(gi)) begin
          part_reg <= slice_sum;
        end
      end
      assign sum[gi*SLICE +: SLICE] = part_reg;
    end
  endgenerate

  assign in_ready  = (state_reg == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state_reg == DONE);
  assign cout      = cout_reg;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: directed cases on a 32/8 instance, random scoreboard on 32/8 and 24/24.
module tb_adder_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid0 = 0, out_ready0 = 0, cin0 = 0;
  logic [31:0] a0 = 0, b0 = 0;
  logic        in_ready0, out_valid0, cout0, busy0;
  logic [31:0] sum0;

  logic        in_valid1 = 0, out_ready1 = 0, cin1 = 0;
  logic [23:0] a1 = 0, b1 = 0;
  logic        in_ready1, out_valid1, cout1, busy1;
  logic [23:0] sum1;

  int checks = 0;
  int errors = 0;

  adder_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .cin(cin0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sum(sum0), .cout(cout0), .busy(busy0)
  );

  adder_seq_ctrl #(.WIDTH(24), .SLICE(24)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  // Issue one op on dut0 and wait for out_valid; lat counts edges from the accepting edge.
  task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic c,
                        output int lat, output logic [31:0] s, output logic co);
    @(negedge clk);
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: in_ready=%0b required 1", in_ready0);
    end
    a0 = a; b0 = b; cin0 = c; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    a0 = $urandom; b0 = $urandom; cin0 = ~c;
    lat = 1;
    while (out_valid0 !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    s = sum0;
    co = cout0;
  endtask

  task automatic consume0();
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL consume: out_valid=%0b in_ready=%0b busy=%0b required 0/1/0",
               out_valid0, in_ready0, busy0);
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic [31:0] es, input logic ec);
    int lat;
    logic [31:0] s;
    logic co;
    issue0(a, b, c, lat, s, co);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges required 5", name, lat);
    end
    checks++;
    if (s !== es || co !== ec) begin
      errors++;
      $display("FAIL %s_result: sum=%08h cout=%0b required sum=%08h cout=%0b", name, s, co, es, ec);
    end
    $display("op %s: a=%08h b=%08h cin=%0b -> sum=%08h cout=%0b lat=%0d", name, a, b, c, s, co, lat);
    consume0();
    checks++;
    if (sum0 !== es || cout0 !== ec) begin
      errors++;
      $display("FAIL %s_hold: sum=%08h cout=%0b required sum=%08h cout=%0b", name, sum0, cout0, es, ec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready0 !== 1 || out_valid0 !== 0 || sum0 !== 32'd0 || cout0 !== 0 || busy0 !== 0) begin
      errors++;
      $display("FAIL reset_dut0: in_ready=%0b out_valid=%0b sum=%08h cout=%0b busy=%0b required 1/0/0/0/0",
               in_ready0, out_valid0, sum0, cout0, busy0);
    end
    checks++;
    if (in_ready1 !== 1 || out_valid1 !== 0 || sum1 !== 24'd0 || cout1 !== 0 || busy1 !== 0) begin
      errors++;
      $display("FAIL reset_dut1: in_ready=%0b out_valid=%0b sum=%06h cout=%0b busy=%0b required 1/0/0/0/0",
               in_ready1, out_valid1, sum1, cout1, busy1);
    end
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_carry_ripple();
    check_op("ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
  endtask

  task automatic test_wrap();
    check_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_cin();
    check_op("cin", 32'h0, 32'h0, 1'b1, 32'h0000_0001, 1'b0);
    check_op("msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] s, ra, rb;
    logic co;
    logic [32:0] full;
    ra = $urandom; rb = $urandom;
    full = {1'b0, ra} + {1'b0, rb} + 33'd1;
    issue0(ra, rb, 1'b1, lat, s, co);
    for (int i = 0; i < 6; i++) begin
      in_valid0 = i[0];
      a0 = $urandom; b0 = $urandom;
      checks++;
      if (out_valid0 !== 1 || in_ready0 !== 0 || busy0 !== 1 ||
          sum0 !== full[31:0] || cout0 !== full[32]) begin
        errors++;
        $display("FAIL backpressure_%0d: out_valid=%0b in_ready=%0b sum=%08h cout=%0b required 1/0 sum=%08h cout=%0b",
                 i, out_valid0, in_ready0, sum0, cout0, full[31:0], full[32]);
      end
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    $display("backpressure: held 6 cycles sum=%08h cout=%0b", sum0, cout0);
    consume0();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid0 !== 0 || in_ready0 !== 1) begin
        errors++;
        $display("FAIL no_second_accept_%0d: out_valid=%0b in_ready=%0b required 0/1", i, out_valid0, in_ready0);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    @(negedge clk);
    a0 = 32'h1234_5678; b0 = 32'h1111_1111; cin0 = 1'b0; in_valid0 = 1'b1;
    @(posedge clk);
    #2 in_valid0 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid0 !== 0 || in_ready0 !== 1 || busy0 !== 0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%0b in_ready=%0b busy=%0b required 0/1/0", out_valid0, in_ready0, busy0);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid0 === 1'b1) seen = 1'b1;
    end
    out_ready0 = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: out_valid seen=%0b required 0", seen);
    end
    $display("reset mid-run: op discarded");
    check_op("after_reset", 32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 32'h0000_0001, 1'b1);
  endtask

  task automatic test_random(input int d, input int n);
    logic [31:0] exp_sum_q[$];
    logic        exp_cout_q[$];
    logic [31:0] mask, ra, rb, es, os;
    logic        rc, ec, oc, ov, ir, ordy, pend;
    logic [32:0] full;
    int sent, got, cyc;
    mask = (d != 0) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
    sent = 0; got = 0; cyc = 0; pend = 1'b0;
    ra = 0; rb = 0; rc = 0;
    while (got < n && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      ov = (d != 0) ? out_valid1 : out_valid0;
      ir = (d != 0) ? in_ready1 : in_ready0;
      os = (d != 0) ? {8'd0, sum1} : sum0;
      oc = (d != 0) ? cout1 : cout0;
      ordy = ($urandom_range(0, 3) != 0);
      if (d != 0) out_ready1 = ordy; else out_ready0 = ordy;
      if (ov && ordy) begin
        checks++;
        got++;
        if (exp_sum_q.size() == 0) begin
          errors++;
          $display("FAIL rand%0d_extra: unexpected result sum=%08h cout=%0b", d, os, oc);
        end else begin
          es = exp_sum_q.pop_front();
          ec = exp_cout_q.pop_front();
          if (os !== es || oc !== ec) begin
            errors++;
            $display("FAIL rand%0d_result_%0d: sum=%08h cout=%0b required sum=%08h cout=%0b",
                     d, got, os, oc, es, ec);
          end else if (got % 100 == 0) begin
            $display("rand%0d txn %0d: sum=%08h cout=%0b", d, got, os, oc);
          end
        end
      end
      if (!pend && sent < n && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 7))
          0: begin ra = 32'hFFFF_FFFF; rb = $urandom; end
          1: begin ra = $urandom; rb = 32'h0; end
          default: begin ra = $urandom; rb = $urandom; end
        endcase
        ra = ra & mask; rb = rb & mask; rc = 1'($urandom);
        pend = 1'b1;
      end
      if (d != 0) begin
        in_valid1 = pend; a1 = pend ? ra[23:0] : 24'($urandom); b1 = pend ? rb[23:0] : 24'($urandom); cin1 = rc;
      end else begin
        in_valid0 = pend; a0 = pend ? ra : $urandom; b0 = pend ? rb : $urandom; cin0 = rc;
      end
      if (pend && ir) begin
        full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
        exp_sum_q.push_back(full[31:0] & mask);
        exp_cout_q.push_back((d != 0) ? full[24] : full[32]);
        sent++;
        pend = 1'b0;
      end
    end
    in_valid0 = 0; in_valid1 = 0; out_ready0 = 0; out_ready1 = 0;
    checks++;
    if (got != n || exp_sum_q.size() != 0) begin
      errors++;
      $display("FAIL rand%0d_count: received %0d pending %0d required %0d and 0",
               d, got, exp_sum_q.size(), n);
    end
    $display("rand%0d: %0d ops sent, %0d results received in %0d cycles", d, sent, got, cyc);
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_wrap();
    test_cin();
    test_backpressure();
    test_reset_mid_run();
    test_random(0, 1000);
    test_random(1, 1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
